// File: rtl/controller_if.sv
// Control bus between the multi-cycle controller and the RV32I datapath.
// Status fields come from the datapath; select/enable fields come from the
// controller. dbg_state mirrors the controller FSM state for observation.
interface controller_if;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;

    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       old_pc_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_function;
    logic [1:0] result_src;
    logic       instr_done;
    logic       halted;
    logic [3:0] dbg_state;

    // Controller side
    modport master (
        input  opcode, f3, f7, zero,
        output adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write,
               imm_src, alu_src_a, alu_src_b, alu_function, result_src,
               instr_done, halted, dbg_state
    );

    // Datapath side
    modport slave (
        output opcode, f3, f7, zero,
        input  adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write,
               imm_src, alu_src_a, alu_src_b, alu_function, result_src,
               instr_done, halted, dbg_state
    );
endinterface

// File: rtl/controller.sv
// Moore-style multi-cycle control FSM for the RV32I subset core.
// One instruction phase per clock; unsupported encodings park in TRAP.
// While reset is low every output is held at 0.
module controller (
    input  logic         clk,
    input  logic         reset,
    controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t     r_state;
    state_t     w_next;
    logic       w_adr_src, w_mem_write, w_ir_write, w_reg_write;
    logic       w_pc_write, w_old_pc_write, w_instr_done, w_halted;
    logic [2:0] w_imm_src, w_alu_function, w_exec_fn;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src;
    logic       w_alu_f3_ok;
    logic       w_unused_f7;

    // Only f7[5] distinguishes SUB from ADD; the other bits are don't-care.
    assign w_unused_f7 = ^{bus.f7[6], bus.f7[4:0]};
    // R/I ALU ops accept every f3 except 001 and 101, which trap.
    assign w_alu_f3_ok = (bus.f3 != 3'b001) && (bus.f3 != 3'b101);

    // State register; reset returns to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // ALU operation for EXEC_R / EXEC_I, selected by f3.
    always_comb begin
        w_exec_fn = 3'd0;
        case (bus.f3)
            3'b000:  w_exec_fn = (r_state == S_EXEC_R && bus.f7[5]) ? 3'd1 : 3'd0;
            3'b111:  w_exec_fn = 3'd2;
            3'b110:  w_exec_fn = 3'd3;
            3'b100:  w_exec_fn = 3'd4;
            3'b010:  w_exec_fn = 3'd5;
            3'b011:  w_exec_fn = 3'd6;
            default: w_exec_fn = 3'd0;
        endcase
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        w_next         = r_state;
        w_adr_src      = 1'b0;
        w_mem_write    = 1'b0;
        w_ir_write     = 1'b0;
        w_reg_write    = 1'b0;
        w_pc_write     = 1'b0;
        w_old_pc_write = 1'b0;
        w_imm_src      = 3'd0;
        w_alu_src_a    = 2'd0;
        w_alu_src_b    = 2'd0;
        w_alu_function = 3'd0;
        w_result_src   = 2'd0;
        w_instr_done   = 1'b0;
        w_halted       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write     = 1'b1;
                w_old_pc_write = 1'b1;
                w_pc_write     = 1'b1;
                w_alu_src_b    = 2'd1;
                w_result_src   = 2'd2;
                w_next         = S_DECODE;
            end
            S_DECODE: begin
                // Branch/JAL target precomputed into the ALU register.
                w_alu_src_a = 2'd1;
                w_alu_src_b = 2'd2;
                if (bus.opcode == OP_BRANCH)   w_imm_src = 3'd2;
                else if (bus.opcode == OP_JAL) w_imm_src = 3'd3;
                w_next = S_TRAP;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: if (bus.f3 == 3'b010) w_next = S_MEM_ADR;
                    OP_R:      if (w_alu_f3_ok) w_next = S_EXEC_R;
                    OP_I:      if (w_alu_f3_ok) w_next = S_EXEC_I;
                    OP_BRANCH: if (bus.f3 == 3'b000 || bus.f3 == 3'b001 ||
                                   bus.f3 == 3'b100 || bus.f3 == 3'b101) w_next = S_BRANCH;
                    OP_JAL:    w_next = S_JAL;
                    OP_JALR:   if (bus.f3 == 3'b000) w_next = S_JALR;
                    OP_LUI:    w_next = S_LUI;
                    default:   w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                w_alu_src_a    = 2'd2;
                w_alu_function = w_exec_fn;
                w_next         = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_alu_src_a    = 2'd2;
                w_alu_src_b    = 2'd2;
                w_alu_function = w_exec_fn;
                w_next         = S_ALU_WB;
            end
            S_MEM_ADR: begin
                w_alu_src_a = 2'd2;
                w_alu_src_b = 2'd2;
                w_imm_src   = (bus.opcode == OP_STORE) ? 3'd1 : 3'd0;
                w_next      = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_adr_src = 1'b1;
                w_next    = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_result_src = 2'd1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ALU_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                // pc_write follows zero combinationally in this state.
                w_alu_src_a  = 2'd2;
                w_instr_done = 1'b1;
                case (bus.f3)
                    3'b000:  begin w_alu_function = 3'd1; w_pc_write = bus.zero;  end
                    3'b001:  begin w_alu_function = 3'd1; w_pc_write = !bus.zero; end
                    3'b100:  begin w_alu_function = 3'd5; w_pc_write = !bus.zero; end
                    3'b101:  begin w_alu_function = 3'd5; w_pc_write = bus.zero;  end
                    default: w_pc_write = 1'b0;
                endcase
                w_next = S_FETCH;
            end
            S_JALR: begin
                w_alu_src_a = 2'd2;
                w_alu_src_b = 2'd2;
                w_next      = S_JAL;
            end
            S_JAL: begin
                // PC takes the target; ALU register captures old PC + 4.
                w_alu_src_a = 2'd1;
                w_alu_src_b = 2'd1;
                w_pc_write  = 1'b1;
                w_next      = S_ALU_WB;
            end
            S_LUI: begin
                w_imm_src    = 3'd4;
                w_result_src = 2'd3;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP: begin
                w_halted = 1'b1;
                w_next   = S_TRAP;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs forced low while reset is asserted, so nothing writes mid-abort.
    assign bus.adr_src      = reset & w_adr_src;
    assign bus.mem_write    = reset & w_mem_write;
    assign bus.ir_write     = reset & w_ir_write;
    assign bus.reg_write    = reset & w_reg_write;
    assign bus.pc_write     = reset & w_pc_write;
    assign bus.old_pc_write = reset & w_old_pc_write;
    assign bus.imm_src      = reset ? w_imm_src      : 3'd0;
    assign bus.alu_src_a    = reset ? w_alu_src_a    : 2'd0;
    assign bus.alu_src_b    = reset ? w_alu_src_b    : 2'd0;
    assign bus.alu_function = reset ? w_alu_function : 3'd0;
    assign bus.result_src   = reset ? w_result_src   : 2'd0;
    assign bus.instr_done   = reset & w_instr_done;
    assign bus.halted       = reset & w_halted;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_controller.sv
// Bench for the multi-cycle controller: directed instructions from the
// test plan, a mid-instruction reset, then randomized instruction streams.
// Each instruction is expanded into its per-cycle control vectors by a
// reference model and compared cycle by cycle.
module tb_controller;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controller_if ifc();
  controller dut (.clk(clk), .reset(reset), .bus(ifc.master));

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] exp_q[$];
  logic [6:0] op_tab [10] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
                              OP_JAL, OP_JALR, OP_LUI, OP_SYS, 7'b0000000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Control vector layout:
  // {adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write,
  //  imm_src[3], alu_src_a[2], alu_src_b[2], alu_function[3], result_src[2],
  //  instr_done, halted}
  function automatic logic [19:0] mk(input logic adr, input logic mw, input logic iw,
      input logic rw, input logic pw, input logic opw, input logic [2:0] imm,
      input logic [1:0] a, input logic [1:0] b, input logic [2:0] fn,
      input logic [1:0] res, input logic done, input logic halt);
    return {adr, mw, iw, rw, pw, opw, imm, a, b, fn, res, done, halt};
  endfunction

  function automatic logic [19:0] sample();
    return {ifc.adr_src, ifc.mem_write, ifc.ir_write, ifc.reg_write, ifc.pc_write,
            ifc.old_pc_write, ifc.imm_src, ifc.alu_src_a, ifc.alu_src_b,
            ifc.alu_function, ifc.result_src, ifc.instr_done, ifc.halted};
  endfunction

  // ALU operation implied by an ALU instruction's funct3 (and SUB for R-type).
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Reference model: expand one instruction into its cycle-by-cycle vectors.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, output bit trap);
    logic [19:0] alu_wb, jal_v;
    logic [2:0]  dimm;
    logic        taken;
    alu_wb = mk(0,0,0,1,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1, 0);
    jal_v  = mk(0,0,0,0,1,0, 3'd0, 2'd1, 2'd1, 3'd0, 2'd0, 0, 0);
    trap = 0;
    exp_q.delete();
    exp_q.push_back(mk(0,0,1,0,1,1, 3'd0, 2'd0, 2'd1, 3'd0, 2'd2, 0, 0));
    dimm = (op == OP_BRANCH) ? 3'd2 : (op == OP_JAL) ? 3'd3 : 3'd0;
    exp_q.push_back(mk(0,0,0,0,0,0, dimm, 2'd1, 2'd2, 3'd0, 2'd0, 0, 0));
    if ((op == OP_LOAD || op == OP_STORE) && f3 == 3'd2) begin
      exp_q.push_back(mk(0,0,0,0,0,0, (op == OP_STORE) ? 3'd1 : 3'd0, 2'd2, 2'd2, 3'd0, 2'd0, 0, 0));
      if (op == OP_LOAD) begin
        exp_q.push_back(mk(1,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
        exp_q.push_back(mk(0,0,0,1,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1, 0));
      end else begin
        exp_q.push_back(mk(1,1,0,0,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1, 0));
      end
    end else if ((op == OP_R || op == OP_I) && f3 != 3'd1 && f3 != 3'd5) begin
      exp_q.push_back(mk(0,0,0,0,0,0, 3'd0, 2'd2, (op == OP_R) ? 2'd0 : 2'd2,
                         alu_of(f3, op == OP_R && f7[5]), 2'd0, 0, 0));
      exp_q.push_back(alu_wb);
    end else if (op == OP_BRANCH && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)) begin
      // beq/bne compare via SUB (zero = equal); blt/bge via SLT (zero = not less).
      case (f3)
        3'd0:    taken = z;
        3'd1:    taken = !z;
        3'd4:    taken = !z;
        default: taken = z;
      endcase
      exp_q.push_back(mk(0,0,0,0,taken,0, 3'd0, 2'd2, 2'd0, f3[2] ? 3'd5 : 3'd1, 2'd0, 1, 0));
    end else if (op == OP_JAL) begin
      exp_q.push_back(jal_v);
      exp_q.push_back(alu_wb);
    end else if (op == OP_JALR && f3 == 3'd0) begin
      exp_q.push_back(mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd2, 3'd0, 2'd0, 0, 0));
      exp_q.push_back(jal_v);
      exp_q.push_back(alu_wb);
    end else if (op == OP_LUI) begin
      exp_q.push_back(mk(0,0,0,1,0,0, 3'd4, 2'd0, 2'd0, 3'd0, 2'd3, 1, 0));
    end else begin
      trap = 1;
      repeat (10) exp_q.push_back(mk(0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 1));
    end
  endtask

  // Reset pulse: outputs must drop at once and stay zero while held.
  task automatic reset_pulse(input string name);
    reset = 1'b0;
    #1 check({name, " rst_now"}, {12'd0, sample()}, 32'd0);
    @(negedge clk);
    check({name, " rst_hold"}, {12'd0, sample()}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Driver: called in a FETCH cycle just after the clock edge.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z);
    bit trap;
    logic [19:0] want;
    int cyc;
    build(op, f3, f7, z, trap);
    ifc.opcode = op; ifc.f3 = f3; ifc.f7 = f7; ifc.zero = z;
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("%s op=%b f3=%0d z=%0d cyc%0d", name, op, f3, z, cyc), {12'd0, sample()}, {12'd0, want});
      @(posedge clk); #1;
      cyc++;
    end
    if (trap) reset_pulse(name);
  endtask

  initial begin
    logic [19:0] want;
    logic [6:0]  op;
    logic [2:0]  f3;
    reset = 1'b0;
    ifc.opcode = 7'($urandom); ifc.f3 = 3'($urandom); ifc.f7 = 7'($urandom); ifc.zero = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {12'd0, sample()}, 32'd0);
      ifc.opcode = 7'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // directed
    run_instr("sub",  OP_R,      3'd0, 7'b0100000, 1'b0);
    run_instr("lw",   OP_LOAD,   3'd2, 7'd0, 1'b0);
    run_instr("sw",   OP_STORE,  3'd2, 7'd0, 1'b0);
    run_instr("beq1", OP_BRANCH, 3'd0, 7'd0, 1'b1);
    run_instr("beq0", OP_BRANCH, 3'd0, 7'd0, 1'b0);
    run_instr("bne0", OP_BRANCH, 3'd1, 7'd0, 1'b0);
    run_instr("blt1", OP_BRANCH, 3'd4, 7'd0, 1'b1);
    run_instr("bge1", OP_BRANCH, 3'd5, 7'd0, 1'b1);
    run_instr("jalr", OP_JALR,   3'd0, 7'd0, 1'b0);
    run_instr("jal",  OP_JAL,    3'd3, 7'd0, 1'b0);
    run_instr("lui",  OP_LUI,    3'd5, 7'd0, 1'b0);
    run_instr("addi", OP_I,      3'd0, 7'b0100000, 1'b0);
    run_instr("sltu", OP_R,      3'd3, 7'd0, 1'b0);
    run_instr("ecall", OP_SYS,   3'd0, 7'd0, 1'b0);
    run_instr("sll",  OP_R,      3'd1, 7'd0, 1'b0);

    // reset asserted in MEM_WB of a load
    build(OP_LOAD, 3'd2, 7'd0, 1'b0, want[0]);
    ifc.opcode = OP_LOAD; ifc.f3 = 3'd2; ifc.f7 = 7'd0;
    for (int c = 0; c < 5; c++) begin
      want = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("midrst lw cyc%0d", c), {12'd0, sample()}, {12'd0, want});
      if (c < 4) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b0;
    #1 check("midrst reg_write", {31'd0, ifc.reg_write}, 32'd0);
    check("midrst outputs", {12'd0, sample()}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr("after_midrst", OP_R, 3'd7, 7'd0, 1'b0);

    // randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      op = op_tab[$urandom_range(0, 9)];
      f3 = 3'($urandom_range(0, 7));
      if ((op == OP_LOAD || op == OP_STORE) && $urandom_range(0, 3) != 0) f3 = 3'd2;
      if (op == OP_JALR && $urandom_range(0, 3) != 0) f3 = 3'd0;
      run_instr("rand", op, f3, 7'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/controller.md
# controller

Moore-style multi-cycle control FSM for the RV32I subset core. It consumes the datapath's `opcode`, `f3`, `f7` and `zero` status outputs. It drives every datapath select and write-enable, one instruction phase per clock. Each instruction takes 3–5 cycles. Unsupported encodings park the core in a trap state until reset.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0].
- `f3` in 3: IR[14:12].
- `f7` in 7: IR[31:25]; only f7[5] is used.
- `zero` in 1: ALU zero flag, combinational from the current ALU operation.
- `adr_src` out 1: 0 = PC, 1 = result.
- `mem_write`, `ir_write`, `reg_write`, `pc_write`, `old_pc_write` out 1 each: write enables.
- `imm_src` out 3: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- `alu_src_a` out 2: 0 = PC, 1 = old PC, 2 = A.
- `alu_src_b` out 2: 0 = B, 1 = constant 4, 2 = immediate.
- `alu_function` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU.
- `result_src` out 2: 0 = ALU register, 1 = MDR, 2 = ALU direct, 3 = immediate.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `halted` out 1: high while in TRAP.

## Operation
- Outputs default to 0 (all enables low, all selects 0, ADD) unless listed below for a state.
- FETCH:
  - `ir_write`, `old_pc_write`, `pc_write` = 1; a = PC, b = 4, ADD, result = ALU direct.
  - Next state: DECODE.
- DECODE:
  - a = old PC, b = imm, ADD; this precomputes the branch/JAL target into the ALU register.
  - `imm_src` is decoded from `opcode`: B for branch, J for jal, else 0.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw), f3 = 010 → MEM_ADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 with f3 ∈ {000, 001, 100, 101} → BRANCH.
    - 1101111 → JAL.
    - 1100111 with f3 = 000 → JALR.
    - 0110111 → LUI.
    - Any other encoding → TRAP.
- EXEC_R / EXEC_I ALU op by f3:
  - 000: ADD; SUB only for R-type with f7[5] = 1.
  - 111: AND. 110: OR. 100: XOR. 010: SLT. 011: SLTU.
  - 001, 101: TRAP, decided in DECODE.
  - Operands: a = A; b = B for R-type, b = imm (`imm_src` = I) for I-type.
  - Next state: ALU_WB.
- MEM_ADR:
  - a = A, b = imm, ADD; `imm_src` = I for lw, S for sw.
  - Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `adr_src` = 1, result = ALU register. Next state: MEM_WB.
- MEM_WB: result = MDR, `reg_write` = 1, `instr_done`. Next state: FETCH.
- MEM_WRITE: `adr_src` = 1, result = ALU register, `mem_write` = 1, `instr_done`. Next state: FETCH.
- ALU_WB: result = ALU register, `reg_write` = 1, `instr_done`. Next state: FETCH.
- BRANCH:
  - a = A, b = B, result = ALU register, `instr_done`.
  - beq: SUB, `pc_write` = `zero`.
  - bne: SUB, `pc_write` = !`zero`.
  - blt: SLT, `pc_write` = !`zero`.
  - bge: SLT, `pc_write` = `zero`.
  - `pc_write` is the only Mealy output. Next state: FETCH.
- JALR: a = A, b = imm (I), ADD; the target goes into the ALU register. Next state: JAL.
- JAL:
  - a = old PC, b = 4, ADD, result = ALU register (the target), `pc_write` = 1.
  - The ALU register captures the link value old PC + 4.
  - Next state: ALU_WB, which writes the link to rd.
- LUI: `imm_src` = U, result = immediate, `reg_write` = 1, `instr_done`. Next state: FETCH.
- TRAP: all enables 0, `halted` = 1. Stays in TRAP until reset.

## Timing
- Reset behaviour:
  - `reset` low asynchronously forces state to FETCH.
  - While `reset` is low, all outputs are forced to 0, overriding FETCH decode.
  - The first FETCH enables assert in the first cycle after `reset` goes high.
- Asserting reset mid-instruction aborts the instruction; no partial write is issued after the assertion.
- Cycles per instruction: R/I-ALU 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui 3.
- Decode outputs are valid from DECODE onward, because IR loads at the end of FETCH.
- `opcode`, `f3` and `f7` must remain stable until the next FETCH.
- `zero` is sampled combinationally in BRANCH; it must settle within the same cycle.
- At most one of `reg_write`, `mem_write`, `ir_write` is high in any cycle.

## Test plan
- Reset held low 3 cycles then released → cycle 1: `ir_write` = `pc_write` = `old_pc_write` = 1, `alu_src_b` = 1, `result_src` = 2; no output is nonzero during reset.
- `opcode` = 0110011, f3 = 000, f7 = 0100000 → state sequence FETCH, DECODE, EXEC_R (`alu_function` = 1, a = 2, b = 0), ALU_WB (`reg_write` = 1, `instr_done` = 1), then FETCH.
- lw (0000011, f3 = 010) → 5 cycles; MEM_READ has `adr_src` = 1; MEM_WB has `result_src` = 1, `reg_write` = 1. sw → MEM_WRITE has `mem_write` = 1 at cycle 4.
- Branches:
  - beq with `zero` = 1 → `pc_write` = 1 in cycle 3.
  - beq with `zero` = 0 → `pc_write` = 0.
  - bge with `zero` = 1 → `pc_write` = 1, `alu_function` = 5.
- jalr (1100111, f3 = 000) → JALR then JAL (`pc_write` = 1, `result_src` = 0, a = 1, b = 1), then ALU_WB with `reg_write` = 1; 5 cycles total.
- Trap and reset mid-instruction:
  - `opcode` = 1110011 → TRAP after DECODE; `halted` = 1 and all enables stay 0 for 10 cycles; `reset` pulse returns to FETCH.
  - `reset` asserted during MEM_WB → `reg_write` drops immediately.
